// File: rtl/eth_arp_receive.sv
// eth_arp_receive: ARP receive/parse; checks Ethernet/ARP headers, latches
// the peer MAC/IP, pulses arp_ack_trig on a request for BOARD_IP and
// arp_rep_done on a reply to BOARD_MAC/BOARD_IP.
// Ports:
//   eth_tx_clk_125m, rst_n (async, active low)
//   rx_en (frame envelope), rx_vld/rx_data (byte stream from preamble)
//   arp_ack_trig, arp_rep_done, frame_drop: one-cycle pulses
//   src_mac, src_ip: sender of the last accepted ARP frame
// Optional: define ARP_RX_FCS_CHECK_EN to verify the Ethernet FCS (CRC32).
module eth_arp_receive #(
    parameter logic [47:0] BOARD_MAC = 48'h2C_FE_07_19_68_33,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd110},
    parameter int          MAX_LEN   = 1526
) (
    input  logic        eth_tx_clk_125m,
    input  logic        rst_n,
    input  logic        rx_en,
    input  logic        rx_vld,
    input  logic [7:0]  rx_data,
    output logic        arp_ack_trig,
    output logic        arp_rep_done,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic        frame_drop
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HEAD,
        ARP_BODY,
        TAIL,
        DROP,
        DECIDE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    // uc/bc: destination MAC still matches unicast / broadcast so far
    logic        uc_q, uc_d;
    logic        bc_q, bc_d;
    logic        rep_q, rep_d;
    logic        tm_q, tm_d;
    logic [47:0] sh_mac_q, sh_mac_d;
    logic [31:0] sh_ip_q, sh_ip_d;
    logic        ack_q, ack_d;
    logic        done_q, done_d;
    logic        drop_q, drop_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] ip_q, ip_d;

    logic [10:0] cnt_inc;
    logic        too_long;
    logic        ok;
    logic [5:0]  off18;
    logic [5:0]  off24;
    logic        crc_ok;

    function automatic logic [7:0] mac_at(input logic [5:0] k);
        logic [47:0] t;
        t = BOARD_MAC << (8 * k);
        return t[47:40];
    endfunction

    function automatic logic [7:0] ip_at(input logic [5:0] k);
        logic [31:0] t;
        t = BOARD_IP << (8 * k);
        return t[31:24];
    endfunction

`ifdef ARP_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Running CRC covers destination MAC through the last FCS byte.
    always_comb begin
        crc_d = crc_q;
        if (rx_en && rx_vld) begin
            if (state_q == PREAMBLE && rx_data == 8'hD5) begin
                crc_d = '1;
            end else if (state_q == ETH_HEAD || state_q == ARP_BODY ||
                         state_q == TAIL) begin
                crc_d = crc_step(crc_q, rx_data);
            end
        end
    end

    always_ff @(posedge eth_tx_clk_125m or negedge rst_n) begin
        if (!rst_n) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign crc_ok = (crc_q == 32'hDEBB_20E3);
`else
    assign crc_ok = 1'b1;
`endif

    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 11'd1;
    assign too_long = cnt_inc > 11'(MAX_LEN);
    assign off18    = idx_q - 6'd18;
    assign off24    = idx_q - 6'd24;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        uc_d     = uc_q;
        bc_d     = bc_q;
        rep_d    = rep_q;
        tm_d     = tm_q;
        sh_mac_d = sh_mac_q;
        sh_ip_d  = sh_ip_q;
        ack_d    = 1'b0;
        done_d   = 1'b0;
        drop_d   = 1'b0;
        mac_d    = mac_q;
        ip_d     = ip_q;
        ok       = 1'b1;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_en && rx_vld) begin
                    cnt_d   = 11'd1;
                    state_d = (rx_data == 8'h55) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!rx_en) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else if (rx_vld) begin
                    cnt_d = cnt_inc;
                    idx_d = '0;
                    uc_d  = 1'b1;
                    bc_d  = 1'b1;
                    if (too_long ||
                        (rx_data != 8'h55 && rx_data != 8'hD5)) begin
                        state_d = DROP;
                    end else if (rx_data == 8'hD5) begin
                        state_d = ETH_HEAD;
                    end
                end
            end
            ETH_HEAD: begin
                if (!rx_en) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else if (rx_vld) begin
                    cnt_d = cnt_inc;
                    idx_d = idx_q + 6'd1;
                    if (idx_q < 6'd6) begin
                        uc_d = uc_q && (rx_data == mac_at(idx_q));
                        bc_d = bc_q && (rx_data == 8'hFF);
                        ok   = uc_d || bc_d;
                    end else if (idx_q == 6'd12) begin
                        ok = (rx_data == 8'h08);
                    end else if (idx_q == 6'd13) begin
                        ok    = (rx_data == 8'h06);
                        idx_d = '0;
                    end
                    if (!ok || too_long) begin
                        state_d = DROP;
                    end else if (idx_q == 6'd13) begin
                        state_d = ARP_BODY;
                    end
                end
            end
            ARP_BODY: begin
                if (!rx_en) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end else if (rx_vld) begin
                    cnt_d = cnt_inc;
                    idx_d = idx_q + 6'd1;
                    case (idx_q)
                        6'd0, 6'd3, 6'd6: ok = (rx_data == 8'h00);
                        6'd1:             ok = (rx_data == 8'h01);
                        6'd2:             ok = (rx_data == 8'h08);
                        6'd4:             ok = (rx_data == 8'h06);
                        6'd5:             ok = (rx_data == 8'h04);
                        6'd7: begin
                            ok    = (rx_data == 8'h01) || (rx_data == 8'h02);
                            rep_d = (rx_data == 8'h02);
                        end
                        6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13:
                            sh_mac_d = {sh_mac_q[39:0], rx_data};
                        6'd14, 6'd15, 6'd16, 6'd17:
                            sh_ip_d = {sh_ip_q[23:0], rx_data};
                        6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23:
                            tm_d = ((idx_q == 6'd18) ? 1'b1 : tm_q) &&
                                   (rx_data == mac_at(off18));
                        6'd24, 6'd25, 6'd26, 6'd27:
                            ok = (rx_data == ip_at(off24));
                        default: ok = 1'b1;
                    endcase
                    if (!ok || too_long) begin
                        state_d = DROP;
                    end else if (idx_q == 6'd27) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (!rx_en) begin
                    state_d = DECIDE;
                end else if (rx_vld) begin
                    cnt_d = cnt_inc;
                    if (too_long) state_d = DROP;
                end
            end
            DECIDE: begin
                state_d = IDLE;
                if (!crc_ok) begin
                    drop_d = 1'b1;
                end else if (!rep_q) begin
                    ack_d = 1'b1;
                    mac_d = sh_mac_q;
                    ip_d  = sh_ip_q;
                end else if (tm_q) begin
                    done_d = 1'b1;
                    mac_d  = sh_mac_q;
                    ip_d   = sh_ip_q;
                end else begin
                    drop_d = 1'b1;
                end
            end
            DROP: begin
                if (!rx_en) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge eth_tx_clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            uc_q     <= 1'b0;
            bc_q     <= 1'b0;
            rep_q    <= 1'b0;
            tm_q     <= 1'b0;
            sh_mac_q <= '0;
            sh_ip_q  <= '0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            mac_q    <= '0;
            ip_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            uc_q     <= uc_d;
            bc_q     <= bc_d;
            rep_q    <= rep_d;
            tm_q     <= tm_d;
            sh_mac_q <= sh_mac_d;
            sh_ip_q  <= sh_ip_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
            mac_q    <= mac_d;
            ip_q     <= ip_d;
        end
    end

    assign arp_ack_trig = ack_q;
    assign arp_rep_done = done_q;
    assign frame_drop   = drop_q;
    assign src_mac      = mac_q;
    assign src_ip       = ip_q;

endmodule

// File: tb/tb_eth_arp_receive.sv
// tb_eth_arp_receive: directed self-checking bench for eth_arp_receive.
// Builds ARP frames (with CRC32 FCS) and checks pulses, latency and src regs.
`timescale 1ns/1ps
module tb_eth_arp_receive;

    localparam logic [47:0] BMAC = 48'h2CFE07196833;
    localparam logic [31:0] BIP  = 32'hC0A8016E;
    localparam logic [47:0] BCST = 48'hFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        ack, rep, drop;
    logic [47:0] smac;
    logic [31:0] sip;

    eth_arp_receive dut (
        .eth_tx_clk_125m(clk),
        .rst_n          (rst_n),
        .rx_en          (rx_en),
        .rx_vld         (rx_vld),
        .rx_data        (rx_data),
        .arp_ack_trig   (ack),
        .arp_rep_done   (rep),
        .src_mac        (smac),
        .src_ip         (sip),
        .frame_drop     (drop)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_ack = 0, n_rep = 0, n_drop = 0;
    int last_ack = -1, last_rep = -1, last_drop = -1;
    always @(negedge clk) begin
        if (ack)  begin n_ack++;  last_ack  = cyc; end
        if (rep)  begin n_rep++;  last_rep  = cyc; end
        if (drop) begin n_drop++; last_drop = cyc; end
    end

    int n_cmp = 0;
    int n_err = 0;
    int t_fall = 0;
    int a0, r0, d0;
    logic [7:0] frm[$];

    task automatic build(input logic [47:0] dst, input logic [15:0] et,
                         input logic [15:0] op, input logic [47:0] sm,
                         input logic [31:0] si, input logic [47:0] tm,
                         input logic [31:0] ti, input int pad);
        logic [31:0] c;
        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(sm[8*i +: 8]);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h01);
        frm.push_back(8'h08); frm.push_back(8'h00);
        frm.push_back(8'h06); frm.push_back(8'h04);
        frm.push_back(op[15:8]); frm.push_back(op[7:0]);
        for (int i = 5; i >= 0; i--) frm.push_back(sm[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(si[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(tm[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(ti[8*i +: 8]);
        repeat (pad) frm.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < frm.size(); i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    // nb < 0 sends the whole frame; gap = extra cycles after rx_en falls
    task automatic send(input bit stall, input int nb, input int gap);
        int n;
        n = (nb < 0) ? frm.size() : nb;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_en = 1'b1; rx_vld = 1'b1; rx_data = frm[i];
            if (stall) begin
                @(posedge clk); #1;
                rx_vld = 1'b0; rx_data = 8'hA5;
            end
        end
        @(posedge clk); #1;
        rx_en = 1'b0; rx_vld = 1'b0; rx_data = 8'h00;
        t_fall = cyc;
        repeat (gap) @(posedge clk);
    endtask

    task automatic snap();
        a0 = n_ack; r0 = n_rep; d0 = n_drop;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", ack); end
        n_cmp++; if (rep !== 1'b0) begin n_err++; $display("FAIL rst_rep: got %b want 0", rep); end
        n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %b want 0", drop); end
        n_cmp++; if (smac !== 48'h0) begin n_err++; $display("FAIL rst_mac: got %h want 0", smac); end
        n_cmp++; if (sip !== 32'h0) begin n_err++; $display("FAIL rst_ip: got %h want 0", sip); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_request_bcast();
        snap();
        build(BCST, 16'h0806, 16'd1, 48'h002B67DD6C1C, 32'hC0A8010B, 48'h0, BIP, 18);
        send(1'b0, -1, 5);
        n_cmp++; if (n_ack - a0 !== 1) begin n_err++; $display("FAIL req_ack_cnt: got %0d want 1", n_ack - a0); end
        n_cmp++; if (last_ack !== t_fall + 2) begin n_err++; $display("FAIL req_ack_lat: got %0d want %0d", last_ack - t_fall, 2); end
        n_cmp++; if (n_rep - r0 + n_drop - d0 !== 0) begin n_err++; $display("FAIL req_other: got %0d want 0", n_rep - r0 + n_drop - d0); end
        n_cmp++; if (smac !== 48'h002B67DD6C1C) begin n_err++; $display("FAIL req_mac: got %h want 002b67dd6c1c", smac); end
        n_cmp++; if (sip !== 32'hC0A8010B) begin n_err++; $display("FAIL req_ip: got %h want c0a8010b", sip); end
    endtask

    task automatic test_reply();
        snap();
        build(BMAC, 16'h0806, 16'd2, 48'h112233445566, 32'hC0A80114, BMAC, BIP, 18);
        send(1'b0, -1, 5);
        n_cmp++; if (n_rep - r0 !== 1) begin n_err++; $display("FAIL rep_cnt: got %0d want 1", n_rep - r0); end
        n_cmp++; if (last_rep !== t_fall + 2) begin n_err++; $display("FAIL rep_lat: got %0d want 2", last_rep - t_fall); end
        n_cmp++; if (n_ack - a0 !== 0) begin n_err++; $display("FAIL rep_ack: got %0d want 0", n_ack - a0); end
        n_cmp++; if (smac !== 48'h112233445566) begin n_err++; $display("FAIL rep_mac: got %h want 112233445566", smac); end
        n_cmp++; if (sip !== 32'hC0A80114) begin n_err++; $display("FAIL rep_ip: got %h want c0a80114", sip); end
    endtask

    task automatic test_wrong_ip();
        snap();
        build(BCST, 16'h0806, 16'd1, 48'hAABBCCDDEEFF, 32'hC0A80105, 48'h0, 32'hC0A8016F, 18);
        send(1'b0, -1, 5);
        n_cmp++; if (n_drop - d0 !== 1) begin n_err++; $display("FAIL wip_drop: got %0d want 1", n_drop - d0); end
        n_cmp++; if (last_drop !== t_fall + 1) begin n_err++; $display("FAIL wip_lat: got %0d want 1", last_drop - t_fall); end
        n_cmp++; if (n_ack - a0 !== 0) begin n_err++; $display("FAIL wip_ack: got %0d want 0", n_ack - a0); end
        n_cmp++; if (smac !== 48'h112233445566) begin n_err++; $display("FAIL wip_mac: got %h want 112233445566", smac); end
        n_cmp++; if (sip !== 32'hC0A80114) begin n_err++; $display("FAIL wip_ip: got %h want c0a80114", sip); end
    endtask

    task automatic test_reply_wrong_tmac();
        snap();
        build(BMAC, 16'h0806, 16'd2, 48'hAABBCCDDEEFF, 32'hC0A80105, 48'h2CFE07196834, BIP, 18);
        send(1'b0, -1, 5);
        n_cmp++; if (n_drop - d0 !== 1) begin n_err++; $display("FAIL wtm_drop: got %0d want 1", n_drop - d0); end
        n_cmp++; if (last_drop !== t_fall + 2) begin n_err++; $display("FAIL wtm_lat: got %0d want 2", last_drop - t_fall); end
        n_cmp++; if (n_rep - r0 !== 0) begin n_err++; $display("FAIL wtm_rep: got %0d want 0", n_rep - r0); end
        n_cmp++; if (smac !== 48'h112233445566) begin n_err++; $display("FAIL wtm_mac: got %h want 112233445566", smac); end
    endtask

    task automatic test_bad_headers();
        for (int k = 0; k < 3; k++) begin
            snap();
            if (k == 0)
                build(48'h2CFE07196834, 16'h0806, 16'd1, 48'h1, 32'h1, 48'h0, BIP, 18);
            else
                build(BCST, 16'h0806, (k == 1) ? 16'd3 : 16'd1, 48'h1, 32'h1, 48'h0, BIP, 18);
            if (k == 2) frm[0] = 8'h00;
            send(1'b0, -1, 5);
            n_cmp++; if (n_drop - d0 !== 1) begin n_err++; $display("FAIL bad%0d_drop: got %0d want 1", k, n_drop - d0); end
            n_cmp++; if (last_drop !== t_fall + 1) begin n_err++; $display("FAIL bad%0d_lat: got %0d want 1", k, last_drop - t_fall); end
            n_cmp++; if (n_ack - a0 !== 0) begin n_err++; $display("FAIL bad%0d_ack: got %0d want 0", k, n_ack - a0); end
        end
    endtask

    task automatic test_back_to_back();
        int tf2;
        snap();
        build(BCST, 16'h0800, 16'd1, 48'h1, 32'h1, 48'h0, BIP, 18);
        send(1'b0, -1, 0);
        build(BCST, 16'h0806, 16'd1, 48'h1, 32'h1, 48'h0, BIP, 18);
        send(1'b0, 28, 0);
        tf2 = t_fall;
        build(BCST, 16'h0806, 16'd1, 48'h002B67DD6C1C, 32'hC0A8010B, 48'h0, BIP, 18);
        send(1'b0, -1, 5);
        n_cmp++; if (n_drop - d0 !== 2) begin n_err++; $display("FAIL b2b_drop: got %0d want 2", n_drop - d0); end
        n_cmp++; if (last_drop !== tf2 + 1) begin n_err++; $display("FAIL b2b_drop_lat: got %0d want 1", last_drop - tf2); end
        n_cmp++; if (n_ack - a0 !== 1) begin n_err++; $display("FAIL b2b_ack: got %0d want 1", n_ack - a0); end
        n_cmp++; if (last_ack !== t_fall + 2) begin n_err++; $display("FAIL b2b_ack_lat: got %0d want 2", last_ack - t_fall); end
        n_cmp++; if (smac !== 48'h002B67DD6C1C) begin n_err++; $display("FAIL b2b_mac: got %h want 002b67dd6c1c", smac); end
    endtask

    task automatic test_stall();
        snap();
        build(BCST, 16'h0806, 16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80133, 48'h0, BIP, 18);
        send(1'b1, -1, 5);
        n_cmp++; if (n_ack - a0 !== 1) begin n_err++; $display("FAIL stall_ack: got %0d want 1", n_ack - a0); end
        n_cmp++; if (last_ack !== t_fall + 2) begin n_err++; $display("FAIL stall_lat: got %0d want 2", last_ack - t_fall); end
        n_cmp++; if (smac !== 48'h0A0B0C0D0E0F) begin n_err++; $display("FAIL stall_mac: got %h want 0a0b0c0d0e0f", smac); end
        n_cmp++; if (sip !== 32'hC0A80133) begin n_err++; $display("FAIL stall_ip: got %h want c0a80133", sip); end
    endtask

    task automatic test_max_len();
        snap();
        build(BCST, 16'h0806, 16'd1, 48'h00000000BEEF, 32'hC0A80177, 48'h0, BIP, 1472);
        send(1'b0, -1, 5);
        n_cmp++; if (n_ack - a0 !== 1) begin n_err++; $display("FAIL len1526_ack: got %0d want 1 (size %0d)", n_ack - a0, frm.size()); end
        n_cmp++; if (sip !== 32'hC0A80177) begin n_err++; $display("FAIL len1526_ip: got %h want c0a80177", sip); end
        snap();
        build(BCST, 16'h0806, 16'd1, 48'h00000000CAFE, 32'hC0A80178, 48'h0, BIP, 1473);
        send(1'b0, -1, 5);
        n_cmp++; if (n_ack - a0 !== 0) begin n_err++; $display("FAIL len1527_ack: got %0d want 0", n_ack - a0); end
        n_cmp++; if (n_drop - d0 !== 1) begin n_err++; $display("FAIL len1527_drop: got %0d want 1", n_drop - d0); end
        n_cmp++; if (last_drop !== t_fall + 1) begin n_err++; $display("FAIL len1527_lat: got %0d want 1", last_drop - t_fall); end
    endtask

    task automatic test_reset_mid();
        build(BCST, 16'h0806, 16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80133, 48'h0, BIP, 18);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            rx_en = 1'b1; rx_vld = 1'b1; rx_data = frm[i];
        end
        #2;
        snap();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (smac !== 48'h0) begin n_err++; $display("FAIL rmid_mac: got %h want 0", smac); end
        n_cmp++; if (sip !== 32'h0) begin n_err++; $display("FAIL rmid_ip: got %h want 0", sip); end
        rx_en = 1'b0; rx_vld = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        n_cmp++; if (n_ack - a0 + n_rep - r0 + n_drop - d0 !== 0) begin n_err++; $display("FAIL rmid_pulses: got %0d want 0", n_ack - a0 + n_rep - r0 + n_drop - d0); end
        snap();
        send(1'b0, -1, 5);
        n_cmp++; if (n_ack - a0 !== 1) begin n_err++; $display("FAIL rmid_next_ack: got %0d want 1", n_ack - a0); end
    endtask

`ifdef ARP_RX_FCS_CHECK_EN
    task automatic test_fcs();
        logic [7:0] b;
        snap();
        build(BCST, 16'h0806, 16'd1, 48'h665544332211, 32'hC0A80142, 48'h0, BIP, 18);
        b = frm[frm.size() - 1];
        frm[frm.size() - 1] = b ^ 8'h01;
        send(1'b0, -1, 5);
        n_cmp++; if (n_drop - d0 !== 1) begin n_err++; $display("FAIL fcs_bad_drop: got %0d want 1", n_drop - d0); end
        n_cmp++; if (last_drop !== t_fall + 2) begin n_err++; $display("FAIL fcs_bad_lat: got %0d want 2", last_drop - t_fall); end
        n_cmp++; if (n_ack - a0 !== 0) begin n_err++; $display("FAIL fcs_bad_ack: got %0d want 0", n_ack - a0); end
        n_cmp++; if (smac !== 48'h0A0B0C0D0E0F) begin n_err++; $display("FAIL fcs_bad_mac: got %h want 0a0b0c0d0e0f", smac); end
        snap();
        frm[frm.size() - 1] = b;
        send(1'b0, -1, 5);
        n_cmp++; if (n_ack - a0 !== 1) begin n_err++; $display("FAIL fcs_ok_ack: got %0d want 1", n_ack - a0); end
        n_cmp++; if (smac !== 48'h665544332211) begin n_err++; $display("FAIL fcs_ok_mac: got %h want 665544332211", smac); end
    endtask
`endif

    initial begin
        test_reset();
        test_request_bcast();
        test_reply();
        test_wrong_ip();
        test_reply_wrong_tmac();
        test_bad_headers();
        test_back_to_back();
        test_stall();
        test_max_len();
        test_reset_mid();
`ifdef ARP_RX_FCS_CHECK_EN
        test_fcs();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
